// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register: issues data-memory accesses,
// stalls the pipeline until ack or timeout, then registers the write-back bundle.
module mem_wb_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_data_i,
    input  logic [4:0]  RegDst_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic        stall_o,
    output logic        err_o,
    output logic [1:0]  WB_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALUResult_o,
    output logic [4:0]  RegDst_o
);

    localparam int CW = $clog2(MAX_WAIT);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    wb_d;
    logic [31:0]   rdata_d;
    logic          err_d;
    logic          req, stall;
    logic          mem_op, aligned, is_load, last_wait;

    assign mem_op    = MemRead_i | MemWrite_i;
    assign aligned   = (Address_i[1:0] == 2'b00);
    // A simultaneous read+write is performed as a write, so no load data
    assign is_load   = MemRead_i & ~MemWrite_i;
    assign last_wait = (cnt_q == CW'(MAX_WAIT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wb_d    = WB_i;
        rdata_d = '0;
        err_d   = err_o;
        req     = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (!aligned) begin
                        err_d = 1'b1;
                        wb_d  = '0;
                    end else begin
                        req     = 1'b1;
                        stall   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = '0;
                        wb_d    = '0;
                        if (MemRead_i & MemWrite_i) err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dmem_ack_i) begin
                    rdata_d = is_load ? dmem_rdata_i : '0;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (last_wait) begin
                    err_d   = 1'b1;
                    wb_d    = '0;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    wb_d  = '0;
                end
            end
        endcase
    end

    // Handshake outputs drop the moment reset asserts, not at the next edge
    assign dmem_req_o   = rst_i & req;
    assign dmem_we_o    = rst_i & req & MemWrite_i;
    assign stall_o      = rst_i & stall;
    assign dmem_addr_o  = {Address_i[31:2], 2'b00};
    assign dmem_wdata_o = Write_data_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_o       <= 1'b0;
            WB_o        <= '0;
            ReadData_o  <= '0;
            ALUResult_o <= '0;
            RegDst_o    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_o       <= err_d;
            WB_o        <= wb_d;
            ReadData_o  <= rdata_d;
            ALUResult_o <= Address_i;
            RegDst_o    <= RegDst_i;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with MAX_WAIT=4.
module tb_mem_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  WB_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] Address_i, Write_data_i;
    logic [4:0]  RegDst_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic        stall_o, err_o;
    logic [1:0]  WB_o;
    logic [31:0] ReadData_o, ALUResult_o;
    logic [4:0]  RegDst_o;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt;

    mem_wb_stage #(.MAX_WAIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .WB_i(WB_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .Address_i(Address_i), .Write_data_i(Write_data_i),
        .RegDst_i(RegDst_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
        .stall_o(stall_o), .err_o(err_o),
        .WB_o(WB_o), .ReadData_o(ReadData_o),
        .ALUResult_o(ALUResult_o), .RegDst_o(RegDst_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [1:0] wb, input logic rd,
                          input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] dst);
        WB_i = wb; MemRead_i = rd; MemWrite_i = wr;
        Address_i = addr; Write_data_i = wd; RegDst_i = dst;
    endtask

    initial begin
        rst_i = 1'b0;
        set_op(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        dmem_rdata_i = '0;
        dmem_ack_i   = 1'b0;
        #3;
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_wb", 32'(WB_o), 32'd0);
        chk("rst_alu", ALUResult_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Non-memory instruction
        @(negedge clk_i);
        set_op(2'b01, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
        #1;
        chk("nm_stall", 32'(stall_o), 32'd0);
        chk("nm_req", 32'(dmem_req_o), 32'd0);
        @(posedge clk_i); #1;
        chk("nm_wb", 32'(WB_o), 32'd1);
        chk("nm_alu", ALUResult_o, 32'h1234);
        chk("nm_rd", 32'(RegDst_o), 32'd5);
        chk("nm_rdata", ReadData_o, 32'd0);

        // Load, ack three cycles after issue
        @(negedge clk_i);
        set_op(2'b11, 1'b1, 1'b0, 32'h100, 32'h0, 5'd7);
        #1;
        chk("ld_req", 32'(dmem_req_o), 32'd1);
        chk("ld_we", 32'(dmem_we_o), 32'd0);
        chk("ld_addr", dmem_addr_o, 32'h100);
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk_i);
                if (i == 3) begin
                    dmem_ack_i   = 1'b1;
                    dmem_rdata_i = 32'hDEADBEEF;
                end
                #1;
                chk("ld_wb_bubble", 32'(WB_o), 32'd0);
            end
            chk("ld_stall_cyc", 32'(stall_o), (i < 3) ? 32'd1 : 32'd0);
            if (stall_o) stall_cnt++;
        end
        chk("ld_stall_total", stall_cnt, 32'd3);
        @(posedge clk_i); #1;
        chk("ld_rdata", ReadData_o, 32'hDEADBEEF);
        chk("ld_wb", 32'(WB_o), 32'd3);
        chk("ld_rd", 32'(RegDst_o), 32'd7);

        // Store, ack on first WAIT cycle, then back-to-back load
        @(negedge clk_i);
        dmem_ack_i = 1'b0;
        set_op(2'b00, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 5'd0);
        #1;
        chk("st_we", 32'(dmem_we_o), 32'd1);
        chk("st_addr", dmem_addr_o, 32'h40);
        chk("st_wdata", dmem_wdata_o, 32'hA5A5A5A5);
        chk("st_stall0", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h12345678;
        #1;
        chk("st_stall1", 32'(stall_o), 32'd0);
        chk("st_req1", 32'(dmem_req_o), 32'd1);
        @(posedge clk_i); #1;
        chk("st_rdata", ReadData_o, 32'd0);
        @(negedge clk_i);
        dmem_ack_i = 1'b0;
        set_op(2'b01, 1'b1, 1'b0, 32'h200, 32'h0, 5'd9);
        #1;
        chk("b2b_req", 32'(dmem_req_o), 32'd1);
        chk("b2b_stall", 32'(stall_o), 32'd1);
        chk("b2b_we", 32'(dmem_we_o), 32'd0);
        @(negedge clk_i);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hCAFEF00D;
        @(posedge clk_i); #1;
        chk("b2b_rdata", ReadData_o, 32'hCAFEF00D);
        chk("b2b_wb", 32'(WB_o), 32'd1);
        chk("b2b_err", 32'(err_o), 32'd0);

        // Misaligned load
        @(negedge clk_i);
        dmem_ack_i = 1'b0;
        set_op(2'b01, 1'b1, 1'b0, 32'h102, 32'h0, 5'd3);
        #1;
        chk("mis_req", 32'(dmem_req_o), 32'd0);
        chk("mis_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        chk("mis_err", 32'(err_o), 32'd1);
        chk("mis_wb", 32'(WB_o), 32'd0);
        chk("mis_alu", ALUResult_o, 32'h102);

        // Reset in the middle of a WAIT
        @(negedge clk_i);
        set_op(2'b11, 1'b1, 1'b0, 32'h400, 32'h0, 5'd4);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("mrst_req", 32'(dmem_req_o), 32'd0);
        chk("mrst_stall", 32'(stall_o), 32'd0);
        chk("mrst_err", 32'(err_o), 32'd0);
        chk("mrst_alu", ALUResult_o, 32'd0);
        chk("mrst_rd", 32'(RegDst_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("post_rst_req", 32'(dmem_req_o), 32'd1);
        chk("post_rst_stall", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h0BADF00D;
        @(posedge clk_i); #1;
        chk("post_rst_rdata", ReadData_o, 32'h0BADF00D);
        chk("post_rst_wb", 32'(WB_o), 32'd3);

        // Timeout, no ack
        @(negedge clk_i);
        dmem_ack_i = 1'b0;
        set_op(2'b11, 1'b1, 1'b0, 32'h300, 32'h0, 5'd6);
        stall_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk_i);
            #1;
            chk("to_stall_cyc", 32'(stall_o), (i < 4) ? 32'd1 : 32'd0);
            if (stall_o) stall_cnt++;
        end
        chk("to_stall_total", stall_cnt, 32'd4);
        chk("to_err_before", 32'(err_o), 32'd0);
        @(posedge clk_i); #1;
        chk("to_err", 32'(err_o), 32'd1);
        chk("to_wb", 32'(WB_o), 32'd0);
        chk("to_rdata", ReadData_o, 32'd0);

        // Stray ack in IDLE
        @(negedge clk_i);
        set_op(2'b01, 1'b0, 1'b0, 32'h500, 32'h0, 5'd2);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'hFFFFFFFF;
        #1;
        chk("idle_ack_req", 32'(dmem_req_o), 32'd0);
        chk("idle_ack_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        chk("idle_ack_rdata", ReadData_o, 32'd0);
        chk("idle_ack_wb", 32'(WB_o), 32'd1);
        chk("idle_ack_alu", ALUResult_o, 32'h500);
        @(negedge clk_i);
        dmem_ack_i = 1'b0;
        #1;
        chk("idle_ack_after", 32'(stall_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
